// File: rtl/gci_std_kmc_ps2_host_tx_50mhz_pkg.sv
// gci_std_kmc_ps2_host_tx_50mhz_pkg: shared PS/2 state encodings, frame size and default interval constants.
package gci_std_kmc_ps2_host_tx_50mhz_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;
  localparam int PS2_FRAME_BITS = 11;
  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_TIMEOUT_CYCLES = 750000;
  localparam int DEF_TIMER_W = 20;
  // Data byte with its odd-parity bit on top, shifted out LSB first.
  function automatic logic [8:0] payload(input logic [7:0] d);
    return {~^d, d};
  endfunction
endpackage

// File: rtl/gci_std_kmc_ps2_host_tx_50mhz_if.sv
// gci_std_kmc_ps2_host_tx_50mhz_if: command request/status bus between KMC core and PS/2 transmitter.
interface gci_std_kmc_ps2_host_tx_50mhz_if;
  logic iREQ;
  logic [7:0] iDATA;
  logic oBUSY;
  logic oDONE;
  logic oERR;
  modport master(output iREQ, iDATA, input oBUSY, oDONE, oERR);
  modport slave(input iREQ, iDATA, output oBUSY, oDONE, oERR);
endinterface

// File: rtl/gci_std_kmc_ps2_tx_timer.sv
// gci_std_kmc_ps2_tx_timer: clearable cycle up-counter with terminal compare.
module gci_std_kmc_ps2_tx_timer #(
  parameter int TIMER_W = 20
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               i_clear,
  input  logic [TIMER_W-1:0] i_limit,
  output logic               o_hit
);
  logic [TIMER_W-1:0] r_cnt;
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) r_cnt <= '0;
    else r_cnt <= i_clear ? '0 : r_cnt + TIMER_W'(1);
  assign o_hit = r_cnt == i_limit;
endmodule

// File: rtl/gci_std_kmc_ps2_host_tx_50mhz.sv
// gci_std_kmc_ps2_host_tx_50mhz: PS/2 host-to-device command transmitter (inhibit, RTS, frame, ack).
module gci_std_kmc_ps2_host_tx_50mhz
  import gci_std_kmc_ps2_host_tx_50mhz_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TIMER_W = DEF_TIMER_W
) (
  input  logic                             iCLOCK,
  input  logic                             inRESET,
  gci_std_kmc_ps2_host_tx_50mhz_if.slave   bus,
  input  logic                             iPS2_CLK,
  input  logic                             iPS2_DAT,
  output logic                             oPS2_CLK_OE,
  output logic                             oPS2_DAT_OE
);
  state_t r_state, w_state;
  logic r_prev, r_dat_oe, w_dat_oe, r_done, w_done, r_err, w_err;
  logic [3:0] r_cnt, w_cnt;
  logic [8:0] r_sh, w_sh;
  logic w_fall, w_hit, w_clr, w_busy;
  logic [TIMER_W-1:0] w_limit;
  assign w_fall = r_prev & ~iPS2_CLK;
  assign w_busy = (r_state != ST_IDLE) | r_done | r_err;
  // One timer serves both intervals: restarted on accept and again on RTS entry.
  assign w_limit = (r_state == ST_INHIBIT) ? TIMER_W'(INHIBIT_CYCLES - 1) : TIMER_W'(TIMEOUT_CYCLES - 1);
  assign w_clr = (r_state == ST_IDLE) | ((r_state == ST_INHIBIT) & w_hit);
  gci_std_kmc_ps2_tx_timer #(.TIMER_W(TIMER_W)) u_timer (
    .iCLOCK (iCLOCK),
    .inRESET(inRESET),
    .i_clear(w_clr),
    .i_limit(w_limit),
    .o_hit  (w_hit)
  );
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_sh = r_sh;
    w_dat_oe = r_dat_oe;
    w_done = 1'b0;
    w_err = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.iREQ && !w_busy) begin
        w_state = ST_INHIBIT;
        w_sh = payload(bus.iDATA);
        w_cnt = '0;
      end
      ST_INHIBIT: begin
        w_dat_oe = 1'b0;
        w_state = w_hit ? ST_RTS : ST_INHIBIT;
      end
      ST_RTS: begin
        w_dat_oe = 1'b1;
        w_state = ST_SHIFT;
      end
      ST_SHIFT: if (w_fall) begin
        w_cnt = r_cnt + 4'd1;
        w_dat_oe = (r_cnt == 4'(PS2_FRAME_BITS - 2)) ? 1'b0 : ~r_sh[0];
        w_sh = r_sh >> 1;
        w_state = (r_cnt == 4'(PS2_FRAME_BITS - 2)) ? ST_ACK : ST_SHIFT;
      end
      ST_ACK: if (w_fall) begin
        w_state = iPS2_DAT ? ST_IDLE : ST_WAIT_IDLE;
        w_err = iPS2_DAT;
      end
      ST_WAIT_IDLE: if (iPS2_CLK && iPS2_DAT) begin
        w_state = ST_IDLE;
        w_done = 1'b1;
      end
      default: w_state = ST_IDLE;
    endcase
    if (w_hit && !w_done && (r_state inside {ST_RTS, ST_SHIFT, ST_ACK, ST_WAIT_IDLE})) begin
      w_state = ST_IDLE;
      w_dat_oe = 1'b0;
      w_err = 1'b1;
    end
  end
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) begin
      r_state <= ST_IDLE;
      r_prev <= 1'b1;
      r_cnt <= '0;
      r_sh <= '0;
      r_dat_oe <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_prev <= iPS2_CLK;
      r_cnt <= w_cnt;
      r_sh <= w_sh;
      r_dat_oe <= w_dat_oe;
      r_done <= w_done;
      r_err <= w_err;
    end
  assign oPS2_CLK_OE = r_state == ST_INHIBIT;
  assign oPS2_DAT_OE = r_dat_oe;
  assign bus.oBUSY = w_busy;
  assign bus.oDONE = r_done;
  assign bus.oERR = r_err;
endmodule

// File: tb/tb_gci_std_kmc_ps2_host_tx_50mhz.sv
// tb_gci_std_kmc_ps2_host_tx_50mhz: PS/2 device model drives the transmitter; intervals scaled down to keep runs short.
module tb_gci_std_kmc_ps2_host_tx_50mhz;
  localparam int INH = 40;
  localparam int TMO = 2500;
  localparam int TW = 12;
  localparam int HALF = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic dev_clk_low, dev_dat_low;
  logic clk_oe, dat_oe, ps2_clk, ps2_dat;
  int checks = 0, fails = 0;

  gci_std_kmc_ps2_host_tx_50mhz_if bus();

  assign ps2_clk = ~(clk_oe | dev_clk_low);
  assign ps2_dat = ~(dat_oe | dev_dat_low);

  gci_std_kmc_ps2_host_tx_50mhz #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .TIMER_W(TW)) dut (
    .iCLOCK     (clk),
    .inRESET    (rst_n),
    .bus        (bus),
    .iPS2_CLK   (ps2_clk),
    .iPS2_DAT   (ps2_dat),
    .oPS2_CLK_OE(clk_oe),
    .oPS2_DAT_OE(dat_oe)
  );

  always #5 clk = ~clk;

  // Line observer: inhibit length, RTS/ERR timestamps, pulse counts.
  int cyc = 0, run = 0, last_run = 0, rts_cyc = 0, err_cyc = 0;
  int inh_starts = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic prev_clk_oe = 1'b0, prev_pulse = 1'b0, busy_after = 1'b1, oe_at_pulse = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (clk_oe && !prev_clk_oe) inh_starts++;
    if (!clk_oe && prev_clk_oe) begin
      last_run = run;
      rts_cyc = cyc;
    end
    run = clk_oe ? run + 1 : 0;
    prev_clk_oe = clk_oe;
    if (prev_pulse) busy_after = bus.oBUSY;
    if (bus.oDONE) done_cnt++;
    if (bus.oERR) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.oDONE && bus.oERR) both_cnt++;
    if (bus.oDONE || bus.oERR) oe_at_pulse = clk_oe | dat_oe;
    prev_pulse = bus.oDONE | bus.oERR;
  end

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic send_req(input logic [7:0] d);
    @(negedge clk);
    bus.iREQ = 1'b1;
    bus.iDATA = d;
    @(negedge clk);
    bus.iREQ = 1'b0;
  endtask

  // Device side: wait for RTS, clock out 10 bits sampling on rising edges, then the ack clock.
  task automatic dev_frame(input bit ack, input int stop_after, output logic [10:0] bits, output bit ok);
    ok = 1'b0;
    bits = '0;
    for (int i = 0; i < INH + 100; i++) begin
      @(negedge clk);
      if (!clk_oe && dat_oe) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    repeat (5) @(negedge clk);
    bits[0] = ps2_dat;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k == stop_after) return;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      bits[k] = ps2_dat;
    end
    dev_dat_low = ack;
    repeat (2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.iREQ = 1'b0;
    bus.iDATA = '0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (clk_oe !== 1'b0) begin fails++; $display("FAIL reset_clk_oe got=%b want=0", clk_oe); end
    checks++; if (dat_oe !== 1'b0) begin fails++; $display("FAIL reset_dat_oe got=%b want=0", dat_oe); end
    checks++; if (bus.oBUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", bus.oBUSY); end
    checks++; if (bus.oDONE !== 1'b0) begin fails++; $display("FAIL reset_done got=%b want=0", bus.oDONE); end
    checks++; if (bus.oERR !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", bus.oERR); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_frame(input logic [7:0] d);
    logic [10:0] bits;
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(d);
    checks++; if (bus.oBUSY !== 1'b1) begin fails++; $display("FAIL frame_busy_after_accept d=%h got=%b want=1", d, bus.oBUSY); end
    dev_frame(1'b1, 0, bits, ok);
    repeat (5) @(negedge clk);
    checks++; if (!ok) begin fails++; $display("FAIL frame_rts_seen d=%h got=0 want=1", d); end
    checks++; if (last_run != INH) begin fails++; $display("FAIL frame_inhibit_len d=%h got=%0d want=%0d", d, last_run, INH); end
    checks++; if (bits !== exp_frame(d)) begin fails++; $display("FAIL frame_bits d=%h got=%b want=%b", d, bits, exp_frame(d)); end
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL frame_done d=%h got=%0d want=1", d, done_cnt - d0); end
    checks++; if (err_cnt - e0 != 0) begin fails++; $display("FAIL frame_err d=%h got=%0d want=0", d, err_cnt - e0); end
    checks++; if (busy_after !== 1'b0) begin fails++; $display("FAIL frame_busy_after_done d=%h got=%b want=0", d, busy_after); end
    checks++; if (both_cnt != 0) begin fails++; $display("FAIL frame_done_and_err got=%0d want=0", both_cnt); end
  endtask

  task automatic test_parity;
    test_frame(8'h01);
    test_frame(8'hFF);
    test_frame(8'h00);
    for (int i = 0; i < 3; i++) test_frame(8'($urandom_range(0, 255)));
  endtask

  task automatic test_timeout;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(8'($urandom_range(0, 255)));
    for (int i = 0; i < INH + TMO + 100 && !bus.oERR; i++) @(negedge clk);
    #1;
    checks++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL timeout_err got=%0d want=1", err_cnt - e0); end
    checks++; if (err_cyc - rts_cyc != TMO) begin fails++; $display("FAIL timeout_latency got=%0d want=%0d", err_cyc - rts_cyc, TMO); end
    checks++; if (oe_at_pulse !== 1'b0) begin fails++; $display("FAIL timeout_oe got=%b want=0", oe_at_pulse); end
    repeat (3) @(negedge clk);
    checks++; if (busy_after !== 1'b0) begin fails++; $display("FAIL timeout_busy_next got=%b want=0", busy_after); end
    checks++; if (done_cnt - d0 != 0) begin fails++; $display("FAIL timeout_done got=%0d want=0", done_cnt - d0); end
  endtask

  task automatic test_no_ack;
    logic [10:0] bits;
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(8'h5A);
    dev_frame(1'b0, 0, bits, ok);
    repeat (5) @(negedge clk);
    checks++; if (bits !== exp_frame(8'h5A)) begin fails++; $display("FAIL noack_bits got=%b want=%b", bits, exp_frame(8'h5A)); end
    checks++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL noack_err got=%0d want=1", err_cnt - e0); end
    checks++; if (done_cnt - d0 != 0) begin fails++; $display("FAIL noack_done got=%0d want=0", done_cnt - d0); end
    checks++; if (bus.oBUSY !== 1'b0) begin fails++; $display("FAIL noack_busy got=%b want=0", bus.oBUSY); end
  endtask

  task automatic test_ignore_busy_req;
    logic [10:0] bits;
    bit ok;
    int s0, d0;
    s0 = inh_starts;
    d0 = done_cnt;
    send_req(8'hED);
    fork
      dev_frame(1'b1, 0, bits, ok);
      begin
        repeat (INH + 60) @(negedge clk);
        bus.iREQ = 1'b1;
        bus.iDATA = 8'h55;
        repeat (3) @(negedge clk);
        bus.iREQ = 1'b0;
      end
    join
    repeat (3 * INH) @(negedge clk);
    checks++; if (bits !== exp_frame(8'hED)) begin fails++; $display("FAIL ignore_bits got=%b want=%b", bits, exp_frame(8'hED)); end
    checks++; if (inh_starts - s0 != 1) begin fails++; $display("FAIL ignore_inhibits got=%0d want=1", inh_starts - s0); end
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL ignore_done got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    logic [10:0] bits;
    bit ok;
    send_req(8'hF0);
    dev_frame(1'b1, 4, bits, ok);
    #2;
    checks++; if (dat_oe !== 1'b1) begin fails++; $display("FAIL rstmid_bit3_driven got=%b want=1", dat_oe); end
    rst_n = 1'b0;
    #1;
    checks++; if (dat_oe !== 1'b0) begin fails++; $display("FAIL rstmid_dat_oe got=%b want=0", dat_oe); end
    checks++; if (clk_oe !== 1'b0) begin fails++; $display("FAIL rstmid_clk_oe got=%b want=0", clk_oe); end
    checks++; if (bus.oBUSY !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b want=0", bus.oBUSY); end
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_frame(8'hAA);
  endtask

  initial begin
    test_reset;
    test_frame(8'hED);
    test_parity;
    test_timeout;
    test_no_ack;
    test_ignore_busy_req;
    test_reset_mid;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
